demux_two_bit_buf: RTL and testbench

- Registered 1-to-4 distributor: the inverse of the 16-bit 4:1 datapath select mux.
- Accepts one 16-bit word per cycle tagged with a 2-bit destination select and steers it into one of four lanes.
- Each lane has its own 2-entry FIFO and a valid/ready handshake toward its consumer.
- Sits between the write-back stage and its four consumers (register file, memory write port, I/O port, debug tap). Lanes drain independently, so one stalled consumer does not block the others.

---
 rtl/demux_two_bit_buf.sv | 137 +++++++++++++
 tb/tb_demux_two_bit_buf.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_two_bit_buf.sv
// Registered 1-to-4 word distributor with a 2-entry FIFO per lane.
// Optional per-lane pop counters are enabled with `define DEMUX_STATS_EN.
module demux_two_bit_buf #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             CLK,
  input  logic             resetN,
  input  logic             flush,
  input  logic [WIDTH-1:0] inData,
  input  logic [1:0]       ctrlSlct,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] outData0,
  output logic [WIDTH-1:0] outData1,
  output logic [WIDTH-1:0] outData2,
  output logic [WIDTH-1:0] outData3,
  output logic             outValid0,
  output logic             outValid1,
  output logic             outValid2,
  output logic             outValid3,
  input  logic             outReady0,
  input  logic             outReady1,
  input  logic             outReady2,
  input  logic             outReady3
`ifdef DEMUX_STATS_EN
  ,
  input  logic [1:0]       statSel,
  output logic [7:0]       statCount
`endif
);

  localparam logic [1:0] Full = 2'(DEPTH);

  logic [3:0][1:0][WIDTH-1:0] mem_q, mem_d;
  logic [3:0][1:0]            count_q, count_d;
  logic [3:0]                 wr_ptr_q, wr_ptr_d;
  logic [3:0]                 rd_ptr_q, rd_ptr_d;

  logic [3:0]            out_ready;
  logic [3:0]            lane_valid;
  logic [3:0]            push;
  logic [3:0]            pop;
  logic [3:0][WIDTH-1:0] lane_data;

  // Ready depends only on the selected lane; a full lane refuses even if it pops this cycle.
  assign inReady = resetN & ~flush & (count_q[ctrlSlct] != Full);

  always_comb begin
    out_ready = {outReady3, outReady2, outReady1, outReady0};
    for (int n = 0; n < 4; n++) begin
      lane_valid[n] = (count_q[n] != 2'd0);
      pop[n]        = lane_valid[n] & out_ready[n];
      push[n]       = inValid & inReady & (ctrlSlct == 2'(n));
      lane_data[n]  = lane_valid[n] ? mem_q[n][rd_ptr_q[n]] : '0;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (push[n]) begin
          mem_d[n][wr_ptr_q[n]] = inData;
          wr_ptr_d[n]           = ~wr_ptr_q[n];
        end
        if (pop[n]) begin
          rd_ptr_d[n] = ~rd_ptr_q[n];
        end
        unique case ({push[n], pop[n]})
          2'b10:   count_d[n] = count_q[n] + 2'd1;
          2'b01:   count_d[n] = count_q[n] - 2'd1;
          default: count_d[n] = count_q[n];
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge resetN) begin
    if (!resetN) begin
      mem_q    <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign outData0  = lane_data[0];
  assign outData1  = lane_data[1];
  assign outData2  = lane_data[2];
  assign outData3  = lane_data[3];
  assign outValid0 = lane_valid[0];
  assign outValid1 = lane_valid[1];
  assign outValid2 = lane_valid[2];
  assign outValid3 = lane_valid[3];

`ifdef DEMUX_STATS_EN
  logic [3:0][7:0] stat_q, stat_d;

  // Pops discarded by flush are not counted; counters saturate rather than wrap.
  always_comb begin
    stat_d = stat_q;
    if (flush) begin
      stat_d = '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (pop[n] && (stat_q[n] != 8'hFF)) begin
          stat_d[n] = stat_q[n] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge resetN) begin
    if (!resetN) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign statCount = stat_q[statSel];
`endif

endmodule

// File: tb/tb_demux_two_bit_buf.sv
// Scoreboard bench for demux_two_bit_buf: per-lane expected queues are filled on accepted
// pushes and drained/compared against the lane heads as consumers pop.
module tb_demux_two_bit_buf;
  localparam int unsigned WIDTH = 16;

  logic             CLK = 1'b0;
  logic             resetN;
  logic             flush;
  logic [WIDTH-1:0] inData;
  logic [1:0]       ctrlSlct;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] outData0, outData1, outData2, outData3;
  logic             outValid0, outValid1, outValid2, outValid3;
  logic [3:0]       out_ready;
  logic [3:0]       out_valid;
  logic [WIDTH-1:0] out_data [4];
`ifdef DEMUX_STATS_EN
  logic [1:0]       statSel;
  logic [7:0]       statCount;
  int unsigned      stat_model [4];
`endif

  logic [WIDTH-1:0] exp_q [4][$];
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  demux_two_bit_buf #(.WIDTH(WIDTH), .DEPTH(2)) dut (
    .CLK       (CLK),
    .resetN    (resetN),
    .flush     (flush),
    .inData    (inData),
    .ctrlSlct  (ctrlSlct),
    .inValid   (inValid),
    .inReady   (inReady),
    .outData0  (outData0),
    .outData1  (outData1),
    .outData2  (outData2),
    .outData3  (outData3),
    .outValid0 (outValid0),
    .outValid1 (outValid1),
    .outValid2 (outValid2),
    .outValid3 (outValid3),
    .outReady0 (out_ready[0]),
    .outReady1 (out_ready[1]),
    .outReady2 (out_ready[2]),
    .outReady3 (out_ready[3])
`ifdef DEMUX_STATS_EN
    ,
    .statSel   (statSel),
    .statCount (statCount)
`endif
  );

  assign out_valid   = {outValid3, outValid2, outValid1, outValid0};
  assign out_data[0] = outData0;
  assign out_data[1] = outData1;
  assign out_data[2] = outData2;
  assign out_data[3] = outData3;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [WIDTH-1:0] d,
                       input logic [3:0] rdy, input logic fl);
    inValid   = v;
    ctrlSlct  = sel;
    inData    = d;
    out_ready = rdy;
    flush     = fl;
  endtask

  // Check everything visible this cycle, advance the model across the coming edge, then clock.
  task automatic tick();
    logic exp_ready;
`ifdef DEMUX_STATS_EN
    statSel = 2'($urandom_range(0, 3));
`endif
    #1;
    exp_ready = !flush && (exp_q[ctrlSlct].size() != 2);
    check_eq("in_ready", 32'(inReady), 32'(exp_ready));
    for (int n = 0; n < 4; n++) begin
      check_eq($sformatf("valid%0d", n), 32'(out_valid[n]), 32'(exp_q[n].size() != 0));
      if (exp_q[n].size() != 0)
        check_eq($sformatf("head%0d", n), 32'(out_data[n]), 32'(exp_q[n][0]));
      else
        check_eq($sformatf("idle%0d", n), 32'(out_data[n]), 32'h0);
    end
`ifdef DEMUX_STATS_EN
    check_eq("stat", 32'(statCount), stat_model[statSel]);
`endif
    if (flush) begin
      for (int n = 0; n < 4; n++) begin
        exp_q[n].delete();
`ifdef DEMUX_STATS_EN
        stat_model[n] = 0;
`endif
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (out_ready[n] && exp_q[n].size() != 0) begin
          void'(exp_q[n].pop_front());
`ifdef DEMUX_STATS_EN
          if (stat_model[n] != 255) stat_model[n]++;
`endif
        end
      end
      if (inValid && exp_ready) exp_q[ctrlSlct].push_back(inData);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    resetN = 1'b0;
    drive(1'b0, 2'd0, '0, 4'b0000, 1'b0);
`ifdef DEMUX_STATS_EN
    statSel = 2'd0;
    for (int n = 0; n < 4; n++) stat_model[n] = 0;
`endif
    #12;
    check_eq("rst_in_ready", 32'(inReady), 32'h0);
    check_eq("rst_valid", 32'(out_valid), 32'h0);
    check_eq("rst_data0", 32'(outData0), 32'h0);
    check_eq("rst_data3", 32'(outData3), 32'h0);
    @(negedge CLK);
    resetN = 1'b1;
    @(posedge CLK);
    #1;

    // Idle after reset
    tick();
    tick();

    // Single word to lane 2
    drive(1'b1, 2'd2, 16'hA5A5, 4'b0000, 1'b0);
    tick();
    drive(1'b0, 2'd0, '0, 4'b0000, 1'b0);
    tick();
    check_eq("lane2_a5a5", 32'(outData2), 32'h0000A5A5);
    check_eq("lane2_only", 32'(out_valid), 32'h4);

    // Fill lane 1; third push must be refused, also while the full lane pops
    drive(1'b1, 2'd1, 16'h0001, 4'b0000, 1'b0);
    tick();
    drive(1'b1, 2'd1, 16'h0002, 4'b0000, 1'b0);
    tick();
    drive(1'b1, 2'd1, 16'h0003, 4'b0000, 1'b0);
    tick();
    drive(1'b1, 2'd1, 16'h0003, 4'b0010, 1'b0);
    #1;
    check_eq("no_passthru", 32'(inReady), 32'h0);
    tick();
    drive(1'b0, 2'd1, '0, 4'b0010, 1'b0);
    tick();
    drive(1'b0, 2'd0, '0, 4'b0000, 1'b0);
    tick();

    // Lane 0 full and stalled; lane 3 still accepts
    drive(1'b1, 2'd0, 16'h00AA, 4'b0000, 1'b0);
    tick();
    drive(1'b1, 2'd0, 16'h00BB, 4'b0000, 1'b0);
    tick();
    drive(1'b1, 2'd3, 16'h1234, 4'b0000, 1'b0);
    tick();
    drive(1'b0, 2'd0, '0, 4'b0000, 1'b0);
    tick();
    check_eq("lane3_1234", 32'(outData3), 32'h00001234);
    check_eq("lane0_kept", 32'(outData0), 32'h000000AA);

    // Lane 1 at count 1: simultaneous push and pop
    drive(1'b1, 2'd1, 16'h0011, 4'b0000, 1'b0);
    tick();
    drive(1'b1, 2'd1, 16'hBEEF, 4'b0010, 1'b0);
    tick();
    drive(1'b0, 2'd0, '0, 4'b0000, 1'b0);
    tick();
    check_eq("lane1_beef", 32'(outData1), 32'h0000BEEF);

    // Flush with a concurrent push to lane 0 and a pop on lane 2
    drive(1'b1, 2'd0, 16'hDEAD, 4'b0100, 1'b1);
    tick();
    drive(1'b0, 2'd0, '0, 4'b0000, 1'b0);
    #1;
    check_eq("flush_valid", 32'(out_valid), 32'h0);
`ifdef DEMUX_STATS_EN
    for (int n = 0; n < 4; n++) begin
      statSel = 2'(n);
      #1;
      check_eq("flush_stat", 32'(statCount), 32'h0);
    end
`endif
    tick();

    // Randomised traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
            4'($urandom), ($urandom_range(0, 31) == 0));
      tick();
    end
    drive(1'b0, 2'd0, '0, 4'b1111, 1'b0);
    tick();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
